// File: rtl/dcache_evict_buffer.sv
// Single-entry write-back eviction buffer between the dcache memory port and the arbiter.
// Lets a refill read overtake a dirty-line eviction, serves hits from the buffered line.
module dcache_evict_buffer #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] dc_address,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              buf_valid
);

  localparam int unsigned TagW = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StResp} state_e;

  state_e state_q, state_d;

  logic              buf_valid_q, buf_valid_d;
  logic [TagW-1:0]   buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0] buf_line_q, buf_line_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              dc_resp_q, dc_resp_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [TagW-1:0] req_tag;
  logic            hit;
  logic            unused_offset;

  assign req_tag       = dc_address[ADDR_W-1:OFFSET_W];
  assign hit           = buf_valid_q && (req_tag == buf_tag_q);
  assign unused_offset = ^dc_address[OFFSET_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A read always wins over a pending drain so the refill reaches memory first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (dc_read) begin
          state_d = hit ? StResp : StRead;
        end else if (dc_write && !buf_valid_q) begin
          state_d = StResp;
        end else if (buf_valid_q) begin
          state_d = StDrain;
        end
      end
      StRead:  if (mem_resp) state_d = StResp;
      StDrain: if (mem_resp) state_d = StIdle;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A write arriving while full is left pending; it is picked up in IDLE after the drain.
  always_comb begin
    buf_valid_d   = buf_valid_q;
    buf_tag_d     = buf_tag_q;
    buf_line_d    = buf_line_q;
    dc_rdata_d    = dc_rdata_q;
    dc_resp_d     = dc_resp_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      StIdle: begin
        if (dc_read && hit) begin
          dc_rdata_d = buf_line_q;
          dc_resp_d  = 1'b1;
        end else if (dc_read) begin
          mem_read_d    = 1'b1;
          mem_address_d = {req_tag, {OFFSET_W{1'b0}}};
        end else if (dc_write && !buf_valid_q) begin
          buf_tag_d   = req_tag;
          buf_line_d  = dc_wdata;
          buf_valid_d = 1'b1;
          dc_resp_d   = 1'b1;
        end else if (buf_valid_q) begin
          mem_write_d   = 1'b1;
          mem_address_d = {buf_tag_q, {OFFSET_W{1'b0}}};
          mem_wdata_d   = buf_line_q;
        end
      end
      StRead: begin
        if (mem_resp) begin
          mem_read_d = 1'b0;
          dc_rdata_d = mem_rdata;
          dc_resp_d  = 1'b1;
        end
      end
      StDrain: begin
        if (mem_resp) begin
          mem_write_d = 1'b0;
          buf_valid_d = 1'b0;
        end
      end
      StResp: begin
        // Inputs ignored: the dcache is still holding the request just completed.
        dc_resp_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q   <= 1'b0;
      buf_tag_q     <= '0;
      buf_line_q    <= '0;
      dc_rdata_q    <= '0;
      dc_resp_q     <= 1'b0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      buf_valid_q   <= buf_valid_d;
      buf_tag_q     <= buf_tag_d;
      buf_line_q    <= buf_line_d;
      dc_rdata_q    <= dc_rdata_d;
      dc_resp_q     <= dc_resp_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign dc_rdata    = dc_rdata_q;
  assign dc_resp     = dc_resp_q;
  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wdata   = mem_wdata_q;
  assign buf_valid   = buf_valid_q;

endmodule

// File: tb/tb_dcache_evict_buffer.sv
// Bench for dcache_evict_buffer: directed dcache traffic, an arbiter model with a line memory,
// and a coherent shadow memory that predicts every line returned to the dcache.
module tb_dcache_evict_buffer;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int OW = 5;

  localparam logic [LW-1:0] DA5 = {32{8'hA5}};
  localparam logic [LW-1:0] D2  = {8{32'hCAFE_0001}};
  localparam logic [LW-1:0] D3  = {8{32'hBEEF_0003}};
  localparam logic [LW-1:0] D4A = {8{32'h4444_000A}};
  localparam logic [LW-1:0] D4B = {8{32'h4444_000B}};
  localparam logic [LW-1:0] D5  = {8{32'h5555_0005}};
  localparam logic [LW-1:0] D6  = {8{32'h6666_0006}};

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] dc_address;
  logic          dc_read;
  logic          dc_write;
  logic [LW-1:0] dc_wdata;
  logic [LW-1:0] dc_rdata;
  logic          dc_resp;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic          buf_valid;

  int checks = 0;
  int passes = 0;

  // Arbiter-side memory and the dcache's view of memory (shadow).
  logic [LW-1:0] arb_mem [logic [AW-1:0]];
  logic [LW-1:0] golden  [logic [AW-1:0]];
  bit            log_wr[$];
  logic [AW-1:0] log_addr[$];
  logic [LW-1:0] log_data[$];
  bit            exp_rd[$];
  logic [LW-1:0] exp_data[$];

  int arb_lat   = 4;
  bit arb_stall = 0;
  int arb_cnt   = 0;

  bit saw_mem_read  = 0;
  bit saw_mem_write = 0;
  int buf_rises     = 0;

  dcache_evict_buffer #(.ADDR_W(AW), .LINE_W(LW), .OFFSET_W(OW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dc_address (dc_address),
    .dc_read    (dc_read),
    .dc_write   (dc_write),
    .dc_wdata   (dc_wdata),
    .dc_rdata   (dc_rdata),
    .dc_resp    (dc_resp),
    .mem_address(mem_address),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .buf_valid  (buf_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] default_pat(input logic [AW-1:0] a);
    return {8{a ^ 32'h1234_5678}};
  endfunction

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return {a[AW-1:OW], {OW{1'b0}}};
  endfunction

  function automatic logic [LW-1:0] model_line(input logic [AW-1:0] a);
    if (golden.exists(line_of(a))) return golden[line_of(a)];
    return default_pat(line_of(a));
  endfunction

  // Arbiter: answers any request after arb_lat cycles unless stalled.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || mem_resp) begin
        mem_resp = 1'b0;
        arb_cnt  = 0;
      end else if ((mem_read || mem_write) && !arb_stall) begin
        arb_cnt++;
        if (arb_cnt >= arb_lat) begin
          mem_resp = 1'b1;
          log_wr.push_back(mem_write);
          log_addr.push_back(mem_address);
          if (mem_write) begin
            arb_mem[mem_address] = mem_wdata;
            log_data.push_back(mem_wdata);
          end else begin
            mem_rdata = arb_mem.exists(mem_address) ? arb_mem[mem_address]
                                                    : default_pat(mem_address);
            log_data.push_back(mem_rdata);
          end
        end
      end
    end
  end

  // Per-cycle compare against the shadow memory and the handshake rules.
  initial begin : cmp
    logic          prev_w, prev_resp, prev_valid;
    logic [AW-1:0] prev_addr;
    logic [LW-1:0] prev_wdata;
    bit            r;
    logic [LW-1:0] d;
    prev_w = 0; prev_resp = 0; prev_valid = 0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_w = 0; prev_resp = 0; prev_valid = 0;
        exp_rd.delete();
        exp_data.delete();
      end else begin
        chk("mem_rw_exclusive", LW'(mem_read && mem_write), '0);
        if (prev_resp) chk("mem_req_drop_after_resp", LW'({mem_read, mem_write}), '0);
        if (mem_read || mem_write) chk("mem_addr_aligned", LW'(mem_address[OW-1:0]), '0);
        if (prev_w && mem_write) begin
          chk("drain_addr_stable", LW'(mem_address), LW'(prev_addr));
          chk("drain_data_stable", mem_wdata, prev_wdata);
        end
        if (dc_resp) begin
          if (exp_rd.size() == 0) begin
            chk("dc_resp_spurious", LW'(dc_resp), '0);
          end else begin
            r = exp_rd.pop_front();
            d = exp_data.pop_front();
            if (r) chk("dc_rdata_model", dc_rdata, d);
          end
        end
        if (mem_read) saw_mem_read = 1;
        if (mem_write) saw_mem_write = 1;
        if (buf_valid && !prev_valid) buf_rises++;
        prev_w     = mem_write;
        prev_resp  = mem_resp;
        prev_valid = buf_valid;
        prev_addr  = mem_address;
        prev_wdata = mem_wdata;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one dcache request; lat counts edges from the first one the buffer can act on.
  task automatic dc_req(input bit is_wr, input logic [AW-1:0] addr, input logic [LW-1:0] data,
                        input bit hold_extra, output int lat);
    dc_address = addr;
    dc_read    = !is_wr;
    dc_write   = is_wr;
    dc_wdata   = is_wr ? data : '0;
    exp_rd.push_back(!is_wr);
    exp_data.push_back(is_wr ? '0 : model_line(addr));
    if (is_wr) golden[line_of(addr)] = data;
    if (dc_resp) cyc();
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!dc_resp && lat < 200);
    chk("dc_resp_seen", LW'(dc_resp), LW'(1));
    if (hold_extra) cyc();
    dc_read  = 1'b0;
    dc_write = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((buf_valid || mem_read || mem_write) && n < 200) begin
      cyc();
      n++;
    end
    chk("wait_idle", LW'({buf_valid, mem_read, mem_write}), '0);
  endtask

  task automatic wait_mem_write();
    int n = 0;
    while (!mem_write && n < 50) begin
      cyc();
      n++;
    end
    chk("mem_write_seen", LW'(mem_write), LW'(1));
  endtask

  initial begin : main
    int lat;
    int base;
    int rises0;
    int n;
    dc_address = '0; dc_read = 0; dc_write = 0; dc_wdata = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_ctrl", LW'({dc_resp, buf_valid, mem_read, mem_write}), '0);
    chk("reset_mem_address", LW'(mem_address), '0);
    chk("reset_dc_rdata", dc_rdata, '0);
    chk("reset_mem_wdata", mem_wdata, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // Empty write, then drain with a 4-cycle arbiter.
    dc_req(1, 32'h0000_1044, DA5, 0, lat);
    chk("t1_write_latency", LW'(lat), LW'(1));
    chk("t1_buf_valid", LW'(buf_valid), LW'(1));
    wait_mem_write();
    chk("t1_mem_address", LW'(mem_address), LW'(32'h0000_1040));
    chk("t1_mem_wdata", mem_wdata, DA5);
    n = 0;
    while (mem_write && n < 50) begin
      cyc();
      n++;
    end
    chk("t1_drain_cycles", LW'(n), LW'(4));
    chk("t1_drained", LW'(buf_valid), '0);

    // Evict then refill: read overtakes the drain.
    base = log_wr.size();
    dc_req(1, 32'h0000_1040, D2, 0, lat);
    dc_req(0, 32'h0000_2008, '0, 0, lat);
    chk("t2_read_latency", LW'(lat), LW'(5));
    chk("t2_rdata", dc_rdata, {8{32'h1234_7678}});
    wait_idle();
    chk("t2_log_count", LW'(log_wr.size() - base), LW'(2));
    if (log_wr.size() >= base + 2) begin
      chk("t2_first_is_read", LW'(log_wr[base]), '0);
      chk("t2_first_addr", LW'(log_addr[base]), LW'(32'h0000_2000));
      chk("t2_drain_addr", LW'(log_addr[base + 1]), LW'(32'h0000_1040));
      chk("t2_drain_data", log_data[base + 1], D2);
    end

    // Buffer hit with the arbiter stalled.
    arb_stall    = 1;
    saw_mem_read = 0;
    dc_req(1, 32'h0000_1040, D3, 0, lat);
    dc_req(0, 32'h0000_105C, '0, 0, lat);
    chk("t3_hit_latency", LW'(lat), LW'(1));
    chk("t3_hit_data", dc_rdata, D3);
    repeat (3) cyc();
    chk("t3_no_mem_read", LW'(saw_mem_read), '0);
    chk("t3_drain_stalled", LW'(mem_write), LW'(1));
    arb_stall = 0;
    wait_idle();
    chk("t3_drain_data", log_data[log_data.size() - 1], D3);

    // Write while full: old line drains first, then the new write is accepted.
    base = log_wr.size();
    dc_req(1, 32'h0000_1040, D4A, 0, lat);
    dc_req(1, 32'h0000_3000, D4B, 0, lat);
    chk("t4_full_write_latency", LW'(lat), LW'(6));
    chk("t4_drained_before_resp", LW'(log_wr.size() - base), LW'(1));
    if (log_wr.size() >= base + 1) begin
      chk("t4_first_drain_addr", LW'(log_addr[base]), LW'(32'h0000_1040));
      chk("t4_first_drain_data", log_data[base], D4A);
    end
    chk("t4_buf_valid", LW'(buf_valid), LW'(1));
    wait_idle();
    if (log_wr.size() >= base + 2) begin
      chk("t4_second_drain_addr", LW'(log_addr[base + 1]), LW'(32'h0000_3000));
      chk("t4_second_drain_data", log_data[base + 1], D4B);
    end else begin
      chk("t4_second_drain_count", LW'(log_wr.size() - base), LW'(2));
    end

    // Asynchronous reset in the middle of a drain.
    arb_stall = 1;
    dc_req(1, 32'h0000_4000, D5, 0, lat);
    wait_mem_write();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_reset", LW'({mem_write, dc_resp, buf_valid}), '0);
    golden = arb_mem;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n       = 1'b1;
    arb_stall     = 0;
    saw_mem_read  = 0;
    saw_mem_write = 0;
    repeat (10) cyc();
    chk("t5_no_traffic", LW'({saw_mem_read, saw_mem_write}), '0);
    chk("t5_buf_empty", LW'(buf_valid), '0);

    // Dcache holds the write through the response cycle.
    base   = log_wr.size();
    rises0 = buf_rises;
    dc_req(1, 32'h0000_5000, D6, 1, lat);
    chk("t6_write_latency", LW'(lat), LW'(1));
    wait_idle();
    chk("t6_single_capture", LW'(buf_rises - rises0), LW'(1));
    chk("t6_single_drain", LW'(log_wr.size() - base), LW'(1));
    if (log_wr.size() >= base + 1) chk("t6_drain_addr", LW'(log_addr[base]), LW'(32'h0000_5000));
    dc_req(0, 32'h0000_5010, '0, 0, lat);
    chk("t6_read_latency", LW'(lat), LW'(5));
    chk("t6_read_data", dc_rdata, D6);
    wait_idle();

    repeat (2) cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
